// File: rtl/cache_arb_pkg.sv
// Shared types for the two-port cache arbiter: FSM states, port index and port names.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef logic port_idx_t;

    localparam port_idx_t PORT_IF = 1'b0;
    localparam port_idx_t PORT_LS = 1'b1;

    function automatic logic [1:0] port_onehot(input port_idx_t p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_port_arbiter_rr.sv
// Two-way picker: round-robin (last-served loses ties) or fixed priority to port 1.
module rr_arbiter2
    import cache_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  last,
    input  logic       fixed,
    output logic [1:0] grant,
    output port_idx_t  idx
);

    port_idx_t favored;
    port_idx_t other;

    always_comb begin
        favored = fixed ? PORT_LS : ~last;
        other   = ~favored;
        grant   = 2'b00;
        idx     = favored;
        if (req[favored]) begin
            grant = port_onehot(favored);
            idx   = favored;
        end else if (req[other]) begin
            grant = port_onehot(other);
            idx   = other;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the cache core port between instruction fetch (port 0) and load/store (port 1),
// one transaction at a time, with a per-transaction watchdog.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W     = 27,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 4096,
    parameter int FIXED_PRIO = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0]             req_we,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             gnt,
    output logic [1:0]             rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic                   err,
    output logic [ADDR_W-1:0]      cache_addr,
    output logic [DATA_W-1:0]      cache_wdata,
    output logic                   cache_write,
    output logic                   cache_enable,
    input  logic [DATA_W-1:0]      cache_rdata,
    input  logic                   cache_available,
    output arb_state_t             dbg_state
);

    // Handshake: req[p] is a level held by the requester until gnt[p]; gnt[p] is the
    // single-cycle accept. rvalid[p] is a single-cycle completion with no backpressure.

    localparam int CNT_W = $clog2(TIMEOUT);

    arb_state_t       state;
    port_idx_t        winner;
    port_idx_t        last;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       arb_grant;
    port_idx_t        arb_idx;

    rr_arbiter2 u_pick (
        .req   (req),
        .last  (last),
        .fixed (FIXED_PRIO != 0),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Gated by rst_n so gnt also reads zero while reset is held.
    assign gnt       = (state == IDLE && rst_n) ? arb_grant : 2'b00;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            winner       <= PORT_IF;
            last         <= PORT_IF;
            cnt          <= '0;
            rvalid       <= 2'b00;
            rdata        <= '0;
            err          <= 1'b0;
            cache_addr   <= '0;
            cache_wdata  <= '0;
            cache_write  <= 1'b0;
            cache_enable <= 1'b0;
        end else begin
            rvalid <= 2'b00;
            case (state)
                IDLE: begin
                    if (|req) begin
                        cache_addr   <= req_addr[arb_idx];
                        cache_write  <= req_we[arb_idx];
                        cache_wdata  <= req_wdata[arb_idx];
                        winner       <= arb_idx;
                        cache_enable <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    cache_enable <= 1'b0;
                    cnt          <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (cache_available) begin
                        if (!cache_write) begin
                            rdata <= cache_rdata;
                        end
                        rvalid <= port_onehot(winner);
                        last   <= winner;
                        state  <= IDLE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        err    <= 1'b1;
                        rdata  <= '0;
                        rvalid <= port_onehot(winner);
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: round-robin instance with a latency-programmable cache
// model, plus a fixed-priority instance with a short watchdog.
module tb_cache_port_arbiter;
    import cache_arb_pkg::*;

    localparam int AW = 27;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]         req;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0]         req_we;
    logic [1:0][DW-1:0] req_wdata;
    logic [1:0]         gnt, rvalid;
    logic [DW-1:0]      rdata;
    logic               err;
    logic [AW-1:0]      cache_addr;
    logic [DW-1:0]      cache_wdata;
    logic               cache_write, cache_enable;
    logic [DW-1:0]      cache_rdata;
    logic               cache_available;
    arb_state_t         dbg_state;

    logic [1:0]         fp_req;
    logic [1:0][AW-1:0] fp_req_addr;
    logic [1:0]         fp_req_we;
    logic [1:0][DW-1:0] fp_req_wdata;
    logic [1:0]         fp_gnt, fp_rvalid;
    logic [DW-1:0]      fp_rdata;
    logic               fp_err;
    logic [AW-1:0]      fp_cache_addr;
    logic [DW-1:0]      fp_cache_wdata;
    logic               fp_cache_write, fp_cache_enable;
    logic [DW-1:0]      fp_cache_rdata;
    logic               fp_avail;
    arb_state_t         fp_dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_we(req_we),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_write(cache_write),
        .cache_enable(cache_enable), .cache_rdata(cache_rdata),
        .cache_available(cache_available), .dbg_state(dbg_state)
    );

    cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req(fp_req), .req_addr(fp_req_addr), .req_we(fp_req_we),
        .req_wdata(fp_req_wdata), .gnt(fp_gnt), .rvalid(fp_rvalid), .rdata(fp_rdata),
        .err(fp_err), .cache_addr(fp_cache_addr), .cache_wdata(fp_cache_wdata),
        .cache_write(fp_cache_write), .cache_enable(fp_cache_enable),
        .cache_rdata(fp_cache_rdata), .cache_available(fp_avail), .dbg_state(fp_dbg_state)
    );

    // Reference model: served-port history, expected read data and shadow memory.
    port_idx_t     last_srv = PORT_IF;
    logic [DW-1:0] exp_rdata = '0;
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] def_data(input logic [AW-1:0] a);
        return 32'h0BAD_0000 ^ {5'b0, a};
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : def_data(a);
    endfunction

    function automatic port_idx_t pick(input logic [1:0] r);
        if (r == 2'b11) return (last_srv == PORT_LS) ? PORT_IF : PORT_LS;
        return r[1] ? PORT_LS : PORT_IF;
    endfunction

    // Cache model: hit when next_lat is 0, else available low for next_lat cycles.
    logic [DW-1:0] cmem [logic [AW-1:0]];
    int            next_lat = 0;
    int            miss_left = 0;
    logic [AW-1:0] c_addr;

    function automatic logic [DW-1:0] c_rd(input logic [AW-1:0] a);
        return cmem.exists(a) ? cmem[a] : def_data(a);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_left       <= 0;
            cache_available <= 1'b1;
            cache_rdata     <= '0;
        end else if (cache_enable) begin
            c_addr <= cache_addr;
            if (cache_write) cmem[cache_addr] = cache_wdata;
            if (next_lat == 0) begin
                cache_available <= 1'b1;
                cache_rdata     <= c_rd(cache_addr);
            end else begin
                cache_available <= 1'b0;
                miss_left       <= next_lat;
            end
        end else if (miss_left > 1) begin
            miss_left <= miss_left - 1;
        end else if (miss_left == 1) begin
            miss_left       <= 0;
            cache_available <= 1'b1;
            cache_rdata     <= c_rd(c_addr);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input port_idx_t p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input int lat);
        req_addr[p]  = a;
        req_we[p]    = we;
        req_wdata[p] = wd;
        req[p]       = 1'b1;
        next_lat     = lat;
        #1;
        chk("gnt", {62'b0, gnt}, {62'b0, port_onehot(p)});
        tick();
        req[p] = 1'b0;
        chk("issue_enable", {63'b0, cache_enable}, 64'd1);
        chk("issue_addr", {37'b0, cache_addr}, {37'b0, a});
        chk("issue_write", {63'b0, cache_write}, {63'b0, we});
        chk("issue_rvalid", {62'b0, rvalid}, 64'd0);
        if (we) chk("issue_wdata", {32'b0, cache_wdata}, {32'b0, wd});
        for (int k = 0; k <= lat; k++) begin
            tick();
            chk("wait_rvalid", {62'b0, rvalid}, 64'd0);
            chk("wait_enable", {63'b0, cache_enable}, 64'd0);
            if (we) chk("wait_wdata", {32'b0, cache_wdata}, {32'b0, wd});
        end
        tick();
        if (we) ref_mem[a] = wd;
        else exp_rdata = ref_rd(a);
        chk("rvalid", {62'b0, rvalid}, {62'b0, port_onehot(p)});
        chk("rdata", {32'b0, rdata}, {32'b0, exp_rdata});
        last_srv = p;
    endtask

    task automatic contend(input int n);
        port_idx_t w;
        req_addr[0] = AW'(32'h200);
        req_addr[1] = AW'(32'h300);
        req_we      = 2'b00;
        next_lat    = 0;
        req         = 2'b11;
        for (int i = 0; i < n; i++) begin
            w = pick(req);
            #1;
            chk("contend_gnt", {62'b0, gnt}, {62'b0, port_onehot(w)});
            tick();
            tick();
            tick();
            exp_rdata = ref_rd(req_addr[w]);
            chk("contend_rvalid", {62'b0, rvalid}, {62'b0, port_onehot(w)});
            chk("contend_rdata", {32'b0, rdata}, {32'b0, exp_rdata});
            last_srv = w;
        end
        req = 2'b00;
    endtask

    port_idx_t     r_p;
    logic          r_we;
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_wd;

    initial begin
        req = 2'b00; req_addr = '0; req_we = 2'b00; req_wdata = '0;
        fp_req = 2'b00; fp_req_addr = '0; fp_req_we = 2'b00; fp_req_wdata = '0;
        fp_cache_rdata = 32'h1111_2222;
        fp_avail = 1'b1;

        // Reset values, including gnt held low while requests are present.
        repeat (3) @(posedge clk);
        #1;
        req = 2'b11;
        fp_req = 2'b11;
        #1;
        chk("rst_gnt", {62'b0, gnt}, 64'd0);
        chk("rst_fp_gnt", {62'b0, fp_gnt}, 64'd0);
        chk("rst_rvalid", {62'b0, rvalid}, 64'd0);
        chk("rst_rdata", {32'b0, rdata}, 64'd0);
        chk("rst_err", {63'b0, err}, 64'd0);
        chk("rst_enable", {63'b0, cache_enable}, 64'd0);
        chk("rst_write", {63'b0, cache_write}, 64'd0);
        chk("rst_addr", {37'b0, cache_addr}, 64'd0);
        chk("rst_wdata", {32'b0, cache_wdata}, 64'd0);
        chk("rst_state", {62'b0, dbg_state}, {62'b0, IDLE});
        req = 2'b00;
        fp_req = 2'b00;
        #1 rst_n = 1'b1;
        tick();

        // Contention straight out of reset: port 1 first, then alternating.
        contend(6);

        // Hit load returning a value placed by a store; then a 20-cycle miss store.
        txn(PORT_LS, 1'b1, AW'(32'h40), 32'hDEAD_BEEF, 0);
        txn(PORT_IF, 1'b0, AW'(32'h40), 32'h0, 0);
        txn(PORT_LS, 1'b1, AW'(32'h1234), 32'hA5A5_A5A5, 20);
        tick();
        chk("store_rvalid_once", {62'b0, rvalid}, 64'd0);

        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                contend(2);
            end else begin
                r_p  = port_idx_t'($urandom_range(0, 1));
                r_we = 1'($urandom_range(0, 1));
                r_a  = AW'(32'h100 + 4 * $urandom_range(0, 7));
                r_wd = $urandom();
                txn(r_p, r_we, r_a, r_wd, int'($urandom_range(0, 6)));
            end
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Reset two cycles into a miss: transaction abandoned, no rvalid.
        req_addr[0] = AW'(32'h80);
        req_we[0]   = 1'b0;
        next_lat    = 10;
        req[0]      = 1'b1;
        tick();
        req[0] = 1'b0;
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", {62'b0, rvalid}, 64'd0);
        chk("midrst_rdata", {32'b0, rdata}, 64'd0);
        chk("midrst_enable", {63'b0, cache_enable}, 64'd0);
        chk("midrst_addr", {37'b0, cache_addr}, 64'd0);
        chk("midrst_state", {62'b0, dbg_state}, {62'b0, IDLE});
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("midrst_no_rvalid", {62'b0, rvalid}, 64'd0);
        end
        #2 rst_n = 1'b1;
        last_srv  = PORT_IF;
        exp_rdata = '0;
        tick();
        txn(PORT_IF, 1'b0, AW'(32'h80), 32'h0, 0);

        // Fixed priority: port 1 wins every contended grant.
        fp_req_addr[0] = AW'(32'h10);
        fp_req_addr[1] = AW'(32'h20);
        fp_req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("fp_gnt", {62'b0, fp_gnt}, 64'd2);
            tick();
            tick();
            tick();
            chk("fp_rvalid", {62'b0, fp_rvalid}, 64'd2);
            chk("fp_rdata", {32'b0, fp_rdata}, 64'h1111_2222);
        end
        fp_req = 2'b00;

        // Watchdog with TIMEOUT=8: eight WAIT cycles, then err and rvalid with zero data.
        fp_avail = 1'b0;
        fp_req   = 2'b01;
        #1;
        chk("fp_lone_gnt", {62'b0, fp_gnt}, 64'd1);
        tick();
        fp_req = 2'b00;
        chk("fp_to_enable", {63'b0, fp_cache_enable}, 64'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("fp_to_err_early", {63'b0, fp_err}, 64'd0);
            chk("fp_to_rvalid_early", {62'b0, fp_rvalid}, 64'd0);
        end
        tick();
        chk("fp_to_err", {63'b0, fp_err}, 64'd1);
        chk("fp_to_rvalid", {62'b0, fp_rvalid}, 64'd1);
        chk("fp_to_rdata", {32'b0, fp_rdata}, 64'd0);
        chk("fp_to_state", {62'b0, fp_dbg_state}, {62'b0, IDLE});

        fp_avail        = 1'b1;
        fp_req_we[1]    = 1'b1;
        fp_req_wdata[1] = 32'h7777_0001;
        fp_req          = 2'b10;
        #1;
        chk("fp_post_gnt", {62'b0, fp_gnt}, 64'd2);
        tick();
        fp_req = 2'b00;
        tick();
        tick();
        chk("fp_post_rvalid", {62'b0, fp_rvalid}, 64'd2);
        chk("fp_post_err", {63'b0, fp_err}, 64'd1);
        chk("fp_post_rdata", {32'b0, fp_rdata}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

- Shares the single core-side port of the direct-mapped data/instruction cache between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Selects one request at a time and drives the cache enable for exactly one cycle. It then waits for the cache's completion, returns read data to the winner, and guards each transaction with a watchdog.
- Sits between the core pipeline and the cache; the cache's DDR2 side is not touched.

## Interface

Parameters:
- `ADDR_W`, default 27: byte-address width, matching the cache.
- `DATA_W`, default 32: word width.
- `TIMEOUT`, default 4096: maximum cycles spent in WAIT before abort. Must be ≥ 2.
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 makes port 1 always win.

Ports (clock and reset first). One clock; reset is asynchronous and active-low.
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `req[1:0]`, in, 2: per-port request level. Held until `gnt`.
- `req_addr[1:0]`, in, 2×`ADDR_W`: byte address. Bits [1:0] are ignored.
- `req_we[1:0]`, in, 2: 1 = store, 0 = load.
- `req_wdata[1:0]`, in, 2×`DATA_W`: store data.
- `gnt[1:0]`, out, 2: one-cycle accept pulse, one-hot or zero.
- `rvalid[1:0]`, out, 2: one-cycle completion pulse. Raised for stores as well as loads.
- `rdata`, out, `DATA_W`: load data, qualified by `rvalid`.
- `err`, out, 1: sticky timeout flag. Cleared only by reset.
- `cache_addr`, out, `ADDR_W`: registered address to the cache.
- `cache_wdata`, out, `DATA_W`: registered write data.
- `cache_write`, out, 1: registered write strobe.
- `cache_enable`, out, 1: one-cycle transaction start.
- `cache_rdata`, in, `DATA_W`: cache read data.
- `cache_available`, in, 1: cache done flag.

## Operation

- FSM states are IDLE, ISSUE and WAIT. Reset state is IDLE.
- **IDLE:**
  - If any `req` bit is set, choose a winner and pulse its `gnt` combinationally in this cycle.
  - Latch `addr`, `we`, `wdata` and the winner index into the `cache_*` registers, then go to ISSUE.
  - With no request, stay in IDLE.
- **Arbitration:**
  - Round-robin: the last-served port has lowest priority. After reset, port 1 (data) has priority.
  - With `FIXED_PRIO`=1, port 1 always wins.
  - A lone requester always wins immediately.
- **ISSUE:** `cache_enable`=1 for exactly this cycle. Go to WAIT; clear the watchdog counter.
- **WAIT:**
  - `cache_available` sampled in WAIT reflects the issued transaction. The cache updates it on the edge that ends ISSUE: 1 on a hit, 0 on a miss, then 1 when the refill ends.
  - On `cache_available`=1: register `rdata`←`cache_rdata` (loads; stores leave `rdata` unchanged), pulse `rvalid[winner]` next cycle, update the round-robin pointer, go to IDLE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`−1: set `err`, pulse `rvalid[winner]` with `rdata`=0, go to IDLE.
- Requests arriving during ISSUE or WAIT are held by the requester. They are not accepted until IDLE.
- **Reset values:** `gnt`=0, `rvalid`=0, `rdata`=0, `err`=0, `cache_enable`=0, `cache_write`=0, `cache_addr`=0, `cache_wdata`=0, round-robin pointer = port 0 last served.
- **Reset asserted in ISSUE or WAIT:** the transaction is abandoned and no `rvalid` is produced. System reset must also quiesce the cache; this is outside this block.

## Timing

- Hit latency: `req`/`gnt` in cycle 0, ISSUE in cycle 1, WAIT in cycle 2 sees available=1, `rvalid` in cycle 3.
- Miss latency: 3 + refill cycles.
- Back-to-back: the earliest next `gnt` is the cycle `rvalid` is high (FSM back in IDLE). Peak throughput is one transaction per 3 cycles.
- `gnt` is combinational from `req` and state; every other output is registered.
- Both requests in IDLE together: exactly one `gnt`. The other request remains pending and wins the next IDLE cycle in round-robin mode.
- Watchdog counter width is $clog2(`TIMEOUT`). It cannot wrap, because it clears in ISSUE.

## Structure

- Package `cache_arb_pkg`:
  - `arb_state_t` enum (IDLE/ISSUE/WAIT)
  - `port_idx_t` (1 bit)
  - `localparam` port names `PORT_IF`=0, `PORT_LS`=1
- Sub-module `rr_arbiter2`: 2-way round-robin/fixed-priority picker. Inputs are `req[1:0]`, `last`, `fixed`. Outputs are one-hot `grant` and an index.
- The top level holds the FSM, the latch registers, the watchdog and the response registers.

## Test plan

- Single hit load: port 0 `req`, addr 0x40; cache returns available=1 with data 0xDEADBEEF in the cycle after ISSUE. Expect `gnt[0]` in cycle 0, `cache_enable` in cycle 1 only, `rvalid[0]` with `rdata`=0xDEADBEEF in cycle 3.
- Miss store: port 1 store, addr 0x1234, data 0xA5A5A5A5; available low for 20 cycles. Expect `cache_write`=1, `cache_wdata`=0xA5A5A5A5 held, `rvalid[1]` exactly once, 1 cycle after available rises, `rdata` unchanged.
- Contention: both ports request continuously for 6 transactions. Expect grants 1,0,1,0,1,0 in round-robin mode; with `FIXED_PRIO`=1 expect all grants to port 1.
- Timeout: `TIMEOUT`=8, available held 0. Expect `err` set after 8 WAIT cycles, `rvalid` with `rdata`=0, FSM back in IDLE; the next `req` is granted normally and `err` stays 1.
- Reset mid-WAIT: deassert `rst_n` 2 cycles into a miss. Expect all outputs at their reset values asynchronously and no `rvalid`. After release, the first request is granted within 1 cycle.
